// File: rtl/tqvp_hx2003_pulse_receiver_pkg.sv
// Shared definitions for the hx2003 pulse transmitter/receiver pair:
// FSM encoding, symbol geometry and counter widths.
package tqvp_hx2003_pulse_receiver_pkg;

   typedef enum logic [1:0] {
      ST_OFF     = 2'd0,
      ST_ARMED   = 2'd1,
      ST_MEASURE = 2'd2,
      ST_FLUSH   = 2'd3
   } rx_state_t;

   localparam int SYM_W         = 2;
   localparam int SYMS_PER_WORD = 16;
   localparam int SLOT_W        = $clog2(SYMS_PER_WORD);
   localparam int CNT_W         = 8;
   localparam int FRAME_CNT_W   = 7;
   localparam int PRESC_W       = 16;

endpackage

// File: rtl/tqvp_hx2003_pulse_receiver_word_fifo.sv
// Captured-word FIFO. A push while full succeeds only alongside a pop;
// a pop while empty is ignored. The head word reads as zero when empty.
module pulse_receiver_word_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [31:0]              push_data,
   input  logic                     pop,
   output logic [31:0]              rd_data,
   output logic                     rd_valid,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     dropped
);

   localparam int AW = $clog2(DEPTH);

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          full;
   logic          pop_ok;
   logic          push_ok;

   assign full     = (count == (AW+1)'(DEPTH));
   assign rd_valid = (count != '0);
   assign pop_ok   = pop && rd_valid;
   assign push_ok  = push && (!full || pop_ok);
   assign dropped  = push && !push_ok;
   assign rd_data  = rd_valid ? mem[rd_ptr] : 32'd0;

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/tqvp_hx2003_pulse_receiver.sv
// Pulse-train receiver: measures segment lengths in prescaled ticks, encodes
// each as a {level, long} symbol and packs 16 symbols per FIFO word.
module tqvp_hx2003_pulse_receiver
   import tqvp_hx2003_pulse_receiver_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rx_in,
   input  logic                          en,
   input  logic                          invert_input,
   input  logic [3:0]                    prescaler,
   input  logic [7:0]                    threshold,
   input  logic [7:0]                    idle_timeout,
   input  logic                          rd_en,
   output logic [31:0]                   rd_data,
   output logic                          rd_valid,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [6:0]                    frame_symbols,
   output logic                          overflow,
   output logic                          irq,
   input  logic                          irq_clear,
   output rx_state_t                     dbg_state
);

   rx_state_t              state, state_d;
   logic [1:0]             sync_q;
   logic                   lvl, lvl_q, edge_det;
   logic [PRESC_W-1:0]     presc;
   logic                   tick;
   logic [CNT_W-1:0]       count;
   logic                   seg_level;
   logic [SLOT_W-1:0]      slot;
   logic [31:0]            word, word_sym;
   logic [SYM_W-1:0]       sym;
   logic [FRAME_CNT_W-1:0] frame_cnt;
   logic                   emit, flush, push, dropped;
   logic [31:0]            push_data;

   assign lvl       = sync_q[1] ^ invert_input;
   assign edge_det  = (lvl != lvl_q);
   assign tick      = (presc == ~({PRESC_W{1'b1}} << prescaler));
   assign sym       = {seg_level, (count >= threshold)};
   assign word_sym  = word | (32'(sym) << (SYM_W * int'(slot)));
   assign dbg_state = state;

   // An edge wins over the timeout, so a segment ending exactly at the
   // timeout is still emitted.
   always_comb begin
      state_d = state;
      emit    = 1'b0;
      flush   = 1'b0;
      unique case (state)
         ST_OFF:     if (en) state_d = ST_ARMED;
         ST_ARMED:   if (edge_det) state_d = ST_MEASURE;
         ST_MEASURE: begin
            emit = edge_det;
            if (!edge_det && idle_timeout != '0 && count == idle_timeout)
               state_d = ST_FLUSH;
         end
         ST_FLUSH: begin
            flush   = 1'b1;
            state_d = ST_ARMED;
         end
      endcase
      if (!en) begin
         state_d = ST_OFF;
         emit    = 1'b0;
         flush   = 1'b0;
      end
   end

   assign push      = (emit && slot == SLOT_W'(SYMS_PER_WORD - 1)) || (flush && slot != '0);
   assign push_data = flush ? word : word_sym;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_OFF;
         sync_q        <= '0;
         lvl_q         <= 1'b0;
         presc         <= '0;
         count         <= '0;
         seg_level     <= 1'b0;
         slot          <= '0;
         word          <= '0;
         frame_cnt     <= '0;
         frame_symbols <= '0;
         overflow      <= 1'b0;
         irq           <= 1'b0;
      end else begin
         state  <= state_d;
         sync_q <= {sync_q[0], rx_in};
         lvl_q  <= lvl;
         if (!en || state == ST_OFF) begin
            presc <= '0;
            count <= '0;
            slot  <= '0;
            word  <= '0;
         end else begin
            presc <= (edge_det || tick) ? '0 : presc + 1'b1;
            unique case (state)
               ST_ARMED: if (edge_det) begin
                  seg_level <= lvl;
                  count     <= '0;
                  frame_cnt <= '0;
               end
               ST_MEASURE: begin
                  if (edge_det) begin
                     seg_level <= lvl;
                     count     <= '0;
                     if (frame_cnt != '1) frame_cnt <= frame_cnt + 1'b1;
                     if (slot == SLOT_W'(SYMS_PER_WORD - 1)) begin
                        word <= '0;
                        slot <= '0;
                     end else begin
                        word <= word_sym;
                        slot <= slot + 1'b1;
                     end
                  end else if (tick && count != '1) begin
                     count <= count + 1'b1;
                  end
               end
               ST_FLUSH: begin
                  word          <= '0;
                  slot          <= '0;
                  count         <= '0;
                  frame_symbols <= frame_cnt;
               end
               default: ;
            endcase
         end
         // A set event takes priority over a simultaneous clear.
         if (dropped)        overflow <= 1'b1;
         else if (irq_clear) overflow <= 1'b0;
         if (flush || dropped) irq <= 1'b1;
         else if (irq_clear)   irq <= 1'b0;
      end
   end

   pulse_receiver_word_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .pop       (rd_en),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .count     (fifo_count),
      .dropped   (dropped)
   );

endmodule

// File: tb/tb_tqvp_hx2003_pulse_receiver.sv
// Directed bench for the pulse receiver: a table of single-frame vectors plus
// hand-written sequences for full words, overflow, saturation, disable and reset.
module tb_tqvp_hx2003_pulse_receiver;
   import tqvp_hx2003_pulse_receiver_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst, rx_in, en, invert_input, rd_en, irq_clear;
   logic [3:0]  prescaler;
   logic [7:0]  threshold, idle_timeout;
   logic [31:0] rd_data;
   logic        rd_valid, overflow, irq;
   logic [2:0]  fifo_count;
   logic [6:0]  frame_symbols;
   rx_state_t   dbg_state;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   tqvp_hx2003_pulse_receiver #(.FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .rx_in(rx_in), .en(en), .invert_input(invert_input),
      .prescaler(prescaler), .threshold(threshold), .idle_timeout(idle_timeout),
      .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .fifo_count(fifo_count),
      .frame_symbols(frame_symbols), .overflow(overflow), .irq(irq),
      .irq_clear(irq_clear), .dbg_state(dbg_state)
   );

   // Segment durations are in clk cycles with prescaler=0; a segment of d
   // cycles ends with count = d-1, so long means d-1 >= threshold.
   typedef struct {
      int              nseg;
      logic [3:0][7:0] dur;
      logic [7:0]      thr;
      logic [31:0]     exp_word;
      logic [6:0]      exp_syms;
   } vec_t;

   vec_t vecs[5];

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_vec(input int i, input int n, input int d0, input int d1, input int d2,
                          input int d3, input int thr, input logic [31:0] w, input int syms);
      vecs[i].nseg     = n;
      vecs[i].dur[0]   = 8'(d0);
      vecs[i].dur[1]   = 8'(d1);
      vecs[i].dur[2]   = 8'(d2);
      vecs[i].dur[3]   = 8'(d3);
      vecs[i].thr      = 8'(thr);
      vecs[i].exp_word = w;
      vecs[i].exp_syms = 7'(syms);
   endtask

   task automatic toggle_train(input int n, input int d);
      for (int i = 0; i < n; i++) begin
         rx_in = ~rx_in;
         step(d);
      end
   endtask

   task automatic do_reset();
      rx_in = 1'b0; rd_en = 1'b0; irq_clear = 1'b0;
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      step(3);
   endtask

   task automatic pop_one();
      rd_en = 1'b1;
      step(1);
      rd_en = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; rx_in = 1'b0; invert_input = 1'b0; rd_en = 1'b0;
      irq_clear = 1'b0; prescaler = 4'd0; threshold = 8'd4; idle_timeout = 8'd20;
      step(2);
      check("reset rd_valid", 32'(rd_valid), 0);
      check("reset fifo_count", 32'(fifo_count), 0);
      check("reset rd_data", rd_data, 0);
      check("reset frame_symbols", 32'(frame_symbols), 0);
      check("reset overflow", 32'(overflow), 0);
      check("reset irq", 32'(irq), 0);
      check("reset state", 32'(dbg_state), 32'(ST_OFF));
      en = 1'b1;

      // Levels alternate 1,0,1,0 starting from a low idle line.
      set_vec(0, 4, 2, 10, 10, 2, 4, 32'h0000_0036, 4);
      set_vec(1, 2, 5, 4, 0, 0, 4, 32'h0000_0003, 2);
      set_vec(2, 1, 3, 0, 0, 0, 4, 32'h0000_0002, 1);
      set_vec(3, 3, 2, 2, 2, 0, 0, 32'h0000_0037, 3);
      set_vec(4, 4, 9, 8, 15, 1, 8, 32'h0000_0033, 4);

      for (int v = 0; v < 5; v++) begin
         do_reset();
         threshold = vecs[v].thr;
         for (int s = 0; s < vecs[v].nseg; s++) begin
            rx_in = ~rx_in;
            step(int'(vecs[v].dur[s]));
         end
         rx_in = ~rx_in;
         step(40);
         check($sformatf("vec%0d rd_data", v), rd_data, vecs[v].exp_word);
         check($sformatf("vec%0d rd_valid", v), 32'(rd_valid), 1);
         check($sformatf("vec%0d fifo_count", v), 32'(fifo_count), 1);
         check($sformatf("vec%0d frame_symbols", v), 32'(frame_symbols), 32'(vecs[v].exp_syms));
         check($sformatf("vec%0d irq", v), 32'(irq), 1);
         check($sformatf("vec%0d state", v), 32'(dbg_state), 32'(ST_ARMED));
         pop_one();
         check($sformatf("vec%0d empty after pop", v), 32'(rd_valid), 0);
      end

      // 16 short alternating segments: full word pushed on the 16th edge,
      // the later FLUSH has slot=0 and pushes nothing.
      do_reset();
      threshold = 8'd4;
      toggle_train(17, 2);
      step(4);
      check("full word count", 32'(fifo_count), 1);
      check("full word data", rd_data, 32'h2222_2222);
      check("full word still measuring", 32'(dbg_state), 32'(ST_MEASURE));
      step(40);
      check("empty flush count", 32'(fifo_count), 1);
      check("full word frame_symbols", 32'(frame_symbols), 16);
      check("full word irq", 32'(irq), 1);

      // Five full words with no reads into a 4-deep FIFO.
      do_reset();
      toggle_train(81, 2);
      step(4);
      check("ovf fifo_count", 32'(fifo_count), 4);
      check("ovf overflow", 32'(overflow), 1);
      check("ovf irq", 32'(irq), 1);
      irq_clear = 1'b1;
      step(1);
      irq_clear = 1'b0;
      check("ovf irq cleared", 32'(irq), 0);
      check("ovf overflow cleared", 32'(overflow), 0);
      step(40);
      check("ovf frame_symbols", 32'(frame_symbols), 80);
      check("ovf fifo still full", 32'(fifo_count), 4);
      irq_clear = 1'b1;
      step(1);
      irq_clear = 1'b0;

      // Push and pop in the same cycle while full; the push lands three
      // clocks after the pin toggle.
      toggle_train(16, 2);
      rx_in = ~rx_in;
      step(2);
      rd_en = 1'b1;
      step(1);
      rd_en = 1'b0;
      check("push+pop full count", 32'(fifo_count), 4);
      check("push+pop full overflow", 32'(overflow), 0);
      step(40);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("drain word%0d", i), rd_data, 32'h2222_2222);
         pop_one();
      end
      check("drain last word", rd_data, 32'h8888_8888);
      pop_one();
      check("drained rd_valid", 32'(rd_valid), 0);
      check("drained rd_data", rd_data, 0);
      pop_one();
      check("pop while empty count", 32'(fifo_count), 0);

      // 300-tick segment with the timeout disabled: count saturates at 255.
      do_reset();
      threshold = 8'd200;
      idle_timeout = 8'd0;
      rx_in = ~rx_in;
      step(300);
      check("no timeout state", 32'(dbg_state), 32'(ST_MEASURE));
      check("no timeout fifo", 32'(fifo_count), 0);
      rx_in = ~rx_in;
      step(2);
      idle_timeout = 8'd20;
      rx_in = ~rx_in;
      step(40);
      check("saturate word", rd_data, 32'h0000_0003);
      check("saturate frame_symbols", 32'(frame_symbols), 2);

      // en dropped mid-frame keeps FIFO contents and raises nothing.
      do_reset();
      threshold = 8'd4;
      toggle_train(2, 3);
      step(40);
      check("pre-disable fifo", 32'(fifo_count), 1);
      irq_clear = 1'b1;
      step(1);
      irq_clear = 1'b0;
      toggle_train(2, 4);
      step(2);
      check("pre-disable state", 32'(dbg_state), 32'(ST_MEASURE));
      en = 1'b0;
      step(1);
      check("disable state", 32'(dbg_state), 32'(ST_OFF));
      step(30);
      check("disable fifo kept", 32'(fifo_count), 1);
      check("disable rd_data kept", rd_data, 32'h0000_0002);
      check("disable no irq", 32'(irq), 0);
      en = 1'b1;
      step(2);

      // Reset mid-frame empties everything.
      toggle_train(2, 5);
      rst = 1'b1;
      step(1);
      check("mid rst state", 32'(dbg_state), 32'(ST_OFF));
      check("mid rst fifo_count", 32'(fifo_count), 0);
      check("mid rst rd_valid", 32'(rd_valid), 0);
      check("mid rst rd_data", rd_data, 0);
      check("mid rst frame_symbols", 32'(frame_symbols), 0);
      check("mid rst irq", 32'(irq), 0);
      rst = 1'b0;
      step(40);
      check("post rst no push", 32'(fifo_count), 0);
      check("post rst no frame_done", 32'(irq), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
